// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared types, rule presets and LFSR helpers for the life engine
package life_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAND = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam logic [8:0]  CONWAY_BIRTH   = 9'b000001000;
    localparam logic [8:0]  CONWAY_SURVIVE = 9'b000001100;

    localparam logic [15:0] LFSR_SEED = 16'h0001;
    // Taps 16/14/13/11 counted from 1, i.e. bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/life_row_next.sv
// rtl/life_row_next.sv - combinational next-generation computation for one board row
//
// Ports:
//   above, cur, below : rows y-1, y, y+1 (already edge-resolved vertically)
//   birth, survive    : rule masks, bit n applies to a cell with n live neighbours
//   next_row          : row y of the next generation
module life_row_next #(
    parameter int LOG_W = 6,
    parameter bit WRAP  = 1'b1
) (
    input  logic [(1<<LOG_W)-1:0] above,
    input  logic [(1<<LOG_W)-1:0] cur,
    input  logic [(1<<LOG_W)-1:0] below,
    input  logic [8:0]            birth,
    input  logic [8:0]            survive,
    output logic [(1<<LOG_W)-1:0] next_row
);

    localparam int W = 1 << LOG_W;

    // Extend each row by one column on both sides so every cell sees the same
    // three-wide window; the pad bits carry the horizontal edge behaviour.
    function automatic logic [W+1:0] pad(input logic [W-1:0] r);
        return WRAP ? {r[0], r, r[W-1]} : {1'b0, r, 1'b0};
    endfunction

    logic [W+1:0] a_e;
    logic [W+1:0] c_e;
    logic [W+1:0] b_e;

    assign a_e = pad(above);
    assign c_e = pad(cur);
    assign b_e = pad(below);

    for (genvar x = 0; x < W; x++) begin : g_col
        logic [3:0] n;
        assign n = 4'(a_e[x]) + 4'(a_e[x+1]) + 4'(a_e[x+2])
                 + 4'(c_e[x])                + 4'(c_e[x+2])
                 + 4'(b_e[x]) + 4'(b_e[x+1]) + 4'(b_e[x+2]);
        assign next_row[x] = cur[x] ? survive[n] : birth[n];
    end

endmodule

// File: rtl/life_engine.sv
// rtl/life_engine.sv - in-place W x H cellular automaton with rule masks and LFSR fill
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   step_req, rand_req      : one-generation / randomise requests, sampled in IDLE
//   rule_birth, rule_survive: rule masks, latched when a step is accepted
//   busy, done              : not-idle flag, one-cycle completion pulse
//   gen_count               : generations since last randomise or reset
//   rd_x, rd_y, rd_cell     : combinational display read port
module life_engine
    import life_pkg::*;
#(
    parameter int LOG_W = 6,
    parameter int LOG_H = 5,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_req,
    input  logic             rand_req,
    input  logic [8:0]       rule_birth,
    input  logic [8:0]       rule_survive,
    output logic             busy,
    output logic             done,
    output logic [15:0]      gen_count,
    input  logic [LOG_W-1:0] rd_x,
    input  logic [LOG_H-1:0] rd_y,
    output logic             rd_cell
);

    localparam int W = 1 << LOG_W;
    localparam int H = 1 << LOG_H;

    logic [W-1:0]           board [H];
    state_t                 state;
    state_t                 state_nx;
    logic [LOG_H-1:0]       y;
    logic [LOG_H-1:0]       y_nx;
    logic [LOG_W+LOG_H-1:0] idx;
    logic [W-1:0]           prev_row;
    logic [W-1:0]           first_row;
    logic [8:0]             birth_l;
    logic [8:0]             survive_l;
    logic [15:0]            lfsr;
    logic [W-1:0]           above;
    logic [W-1:0]           below;
    logic [W-1:0]           row_nx;

    assign y_nx = y + 1'b1;

    // Rows above the current one have already been overwritten, so the
    // original row y-1 comes from prev_row and the original row 0 (needed as
    // the wrap-around neighbour of the last row) from first_row.
    always_comb begin
        above = '0;
        below = '0;
        if (y == '0) begin
            if (WRAP) above = board[H-1];
        end else begin
            above = prev_row;
        end
        if (&y) begin
            if (WRAP) below = first_row;
        end else begin
            below = board[y_nx];
        end
    end

    life_row_next #(
        .LOG_W (LOG_W),
        .WRAP  (WRAP)
    ) u_row_next (
        .above    (above),
        .cur      (board[y]),
        .below    (below),
        .birth    (birth_l),
        .survive  (survive_l),
        .next_row (row_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (rand_req)      state_nx = RAND;
                else if (step_req) state_nx = STEP;
            end
            RAND:    if (&idx) state_nx = IDLE;
            STEP:    if (&y)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < H; r++) board[r] <= '0;
            y         <= '0;
            idx       <= '0;
            prev_row  <= '0;
            first_row <= '0;
            birth_l   <= '0;
            survive_l <= '0;
            lfsr      <= LFSR_SEED;
            done      <= 1'b0;
            gen_count <= '0;
        end else begin
            lfsr <= lfsr_next(lfsr);
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rand_req) begin
                        idx <= '0;
                    end else if (step_req) begin
                        y         <= '0;
                        birth_l   <= rule_birth;
                        survive_l <= rule_survive;
                    end
                end
                RAND: begin
                    board[idx[LOG_W+LOG_H-1:LOG_W]][idx[LOG_W-1:0]] <= lfsr[0];
                    idx <= idx + 1'b1;
                    if (&idx) begin
                        done      <= 1'b1;
                        gen_count <= '0;
                    end
                end
                STEP: begin
                    board[y] <= row_nx;
                    prev_row <= board[y];
                    if (y == '0) first_row <= board[y];
                    y <= y_nx;
                    if (&y) begin
                        done      <= 1'b1;
                        gen_count <= gen_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign rd_cell = board[rd_y][rd_x];

endmodule

// File: tb/tb_life_engine.sv
// tb/tb_life_engine.sv - randomized self-checking bench for life_engine against a whole-board model
module tb_life_engine;
    import life_pkg::*;

    localparam int LOG_W = 6;
    localparam int LOG_H = 5;
    localparam int W  = 1 << LOG_W;
    localparam int H  = 1 << LOG_H;
    localparam int WH = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step_req = 1'b0;
    logic       rand_req = 1'b0;
    logic [8:0] rule_birth = CONWAY_BIRTH;
    logic [8:0] rule_survive = CONWAY_SURVIVE;
    logic [5:0] rd_x = '0;
    logic [4:0] rd_y = '0;

    logic        busy0, busy1, done0, done1, cell0, cell1;
    logic [15:0] gen0, gen1;

    always #5 clk = ~clk;

    life_engine #(.LOG_W(LOG_W), .LOG_H(LOG_H), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .step_req(step_req), .rand_req(rand_req),
        .rule_birth(rule_birth), .rule_survive(rule_survive),
        .busy(busy0), .done(done0), .gen_count(gen0),
        .rd_x(rd_x), .rd_y(rd_y), .rd_cell(cell0)
    );

    life_engine #(.LOG_W(LOG_W), .LOG_H(LOG_H), .WRAP(1'b0)) u_dead (
        .clk(clk), .rst_n(rst_n), .step_req(step_req), .rand_req(rand_req),
        .rule_birth(rule_birth), .rule_survive(rule_survive),
        .busy(busy1), .done(done1), .gen_count(gen1),
        .rd_x(rd_x), .rd_y(rd_y), .rd_cell(cell1)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit g_src [H][W];
    bit g_dst [H][W];

    function automatic int nb(input int x, input int y, input bit wrap);
        if (wrap) return int'(g_src[(y + H) % H][(x + W) % W]);
        if (x < 0 || x >= W || y < 0 || y >= H) return 0;
        return int'(g_src[y][x]);
    endfunction

    function automatic void life_next(input bit wrap, input logic [8:0] b, input logic [8:0] s);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                int n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dx != 0 || dy != 0) n += nb(x + dx, y + dy, wrap);
                g_dst[y][x] = g_src[y][x] ? s[n] : b[n];
            end
    endfunction

    function automatic void clear_src();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) g_src[y][x] = 1'b0;
    endfunction

    function automatic int dst_ones();
        int c = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) c += int'(g_dst[y][x]);
        return c;
    endfunction

    function automatic void dst_to_src();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) g_src[y][x] = g_dst[y][x];
    endfunction

    function automatic logic [15:0] ref_lfsr(input logic [15:0] l);
        logic fb;
        fb = l[15] ^ l[13] ^ l[12] ^ l[10];
        return {l[14:0], fb};
    endfunction

    bit          mb    [2][H][W];
    bit          mnext [2][H][W];
    int          m_mode;
    int          m_cnt;
    bit          m_done;
    logic [15:0] m_gen;
    logic [15:0] m_lfsr;

    // Model advances at every clock edge; a step computes the whole next
    // generation from the board as it stood at acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++)
                for (int y = 0; y < H; y++)
                    for (int x = 0; x < W; x++) mb[i][y][x] = 1'b0;
            m_mode = 0; m_cnt = 0; m_done = 1'b0; m_gen = 16'd0; m_lfsr = 16'h0001;
        end else begin
            m_done = 1'b0;
            case (m_mode)
                0: begin
                    if (rand_req) begin
                        m_mode = 1; m_cnt = 0;
                    end else if (step_req) begin
                        m_mode = 2; m_cnt = 0;
                        for (int i = 0; i < 2; i++) begin
                            for (int y = 0; y < H; y++)
                                for (int x = 0; x < W; x++) g_src[y][x] = mb[i][y][x];
                            life_next(i == 0, rule_birth, rule_survive);
                            for (int y = 0; y < H; y++)
                                for (int x = 0; x < W; x++) mnext[i][y][x] = g_dst[y][x];
                        end
                    end
                end
                1: begin
                    mb[0][m_cnt / W][m_cnt % W] = m_lfsr[0];
                    mb[1][m_cnt / W][m_cnt % W] = m_lfsr[0];
                    m_cnt++;
                    if (m_cnt == WH) begin m_mode = 0; m_done = 1'b1; m_gen = 16'd0; end
                end
                default: begin
                    m_cnt++;
                    if (m_cnt == H) begin
                        mb = mnext;
                        m_mode = 0; m_done = 1'b1; m_gen = m_gen + 16'd1;
                    end
                end
            endcase
            m_lfsr = ref_lfsr(m_lfsr);
        end
    end

    // Per-cycle compare, sampled 2 time units after the active edge.
    always @(posedge clk) begin
        #2;
        chk("busy_wrap", busy0, m_mode != 0);
        chk("busy_dead", busy1, m_mode != 0);
        chk("done_wrap", done0, m_done);
        chk("done_dead", done1, m_done);
        chk("gen_wrap", gen0, m_gen);
        chk("gen_dead", gen1, m_gen);
        if (m_mode == 0 && rst_n) begin
            chk("cell_wrap", cell0, mb[0][rd_y][rd_x]);
            chk("cell_dead", cell1, mb[1][rd_y][rd_x]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic scan(output int ones0, output int ones1);
        ones0 = 0; ones1 = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                @(negedge clk);
                rd_x = 6'(x); rd_y = 5'(y);
                #1;
                ones0 += int'(cell0);
                ones1 += int'(cell1);
            end
    endtask

    task automatic run_op(input bit is_rand, input logic [8:0] b, input logic [8:0] s,
                          input bit jitter, output int lat);
        @(negedge clk);
        rule_birth = b; rule_survive = s;
        step_req = 1'b1;
        rand_req = is_rand;
        @(negedge clk);
        rand_req = 1'b0; step_req = 1'b0; lat = 0;
        while (!done0 && lat < 3000) begin
            if (jitter && m_mode != 0) begin
                step_req     = 1'($urandom_range(0, 1));
                rand_req     = ($urandom_range(0, 7) == 0);
                rule_birth   = 9'($urandom);
                rule_survive = 9'($urandom);
            end else begin
                step_req = 1'b0; rand_req = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        rand_req = 1'b0; step_req = 1'b0;
        if (!done0) chk("op_timeout", done0, 1);
    endtask

    int lat, o0, o1;
    logic [8:0] rb, rs;

    initial begin
        // model pins: hand-derived expectations for the reference rules
        clear_src();
        g_src[5][10] = 1'b1; g_src[5][11] = 1'b1; g_src[5][12] = 1'b1;
        life_next(1'b1, CONWAY_BIRTH, CONWAY_SURVIVE);
        chk("pin_blinker1_n", dst_ones(), 3);
        chk("pin_blinker1_cells", {g_dst[4][11], g_dst[5][11], g_dst[6][11]}, 3'b111);
        dst_to_src();
        life_next(1'b1, CONWAY_BIRTH, CONWAY_SURVIVE);
        chk("pin_blinker2_n", dst_ones(), 3);
        chk("pin_blinker2_cells", {g_dst[5][10], g_dst[5][11], g_dst[5][12]}, 3'b111);

        clear_src();
        g_src[0][63] = 1'b1; g_src[0][0] = 1'b1; g_src[0][1] = 1'b1;
        life_next(1'b1, CONWAY_BIRTH, CONWAY_SURVIVE);
        chk("pin_edge_wrap_n", dst_ones(), 3);
        chk("pin_edge_wrap_cells", {g_dst[31][0], g_dst[0][0], g_dst[1][0]}, 3'b111);
        life_next(1'b0, CONWAY_BIRTH, CONWAY_SURVIVE);
        chk("pin_edge_dead_n", dst_ones(), 0);

        clear_src();
        g_src[10][20] = 1'b1;
        life_next(1'b1, 9'b000000010, 9'b0);
        chk("pin_single_n", dst_ones(), 8);
        chk("pin_single_ring", {g_dst[9][19], g_dst[9][20], g_dst[9][21], g_dst[10][19],
                                g_dst[10][21], g_dst[11][19], g_dst[11][20], g_dst[11][21]}, 8'hFF);
        chk("pin_single_centre", g_dst[10][20], 0);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_gen", gen0, 0);
        rst_n = 1'b1;

        // empty board step
        run_op(1'b0, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b0, lat);
        chk("empty_step_latency", lat, H);
        chk("empty_step_gen", gen0, 1);
        scan(o0, o1);
        chk("empty_step_ones", o0 + o1, 0);

        // rand has priority over a simultaneous step
        run_op(1'b1, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1, lat);
        chk("rand_latency", lat, WH);
        chk("rand_gen", gen0, 0);
        scan(o0, o1);
        chk("rand_nonzero", o0 != 0, 1);

        // steps with junk requests and rule changes while busy
        for (int i = 0; i < 6; i++) begin
            if (i % 3 == 0) begin rb = CONWAY_BIRTH; rs = CONWAY_SURVIVE; end
            else begin rb = 9'($urandom) & 9'h1FE; rs = 9'($urandom); end
            run_op(1'b0, rb, rs, 1'b1, lat);
            chk("step_latency", lat, H);
            chk("step_gen", gen1, 16'(i + 1));
            scan(o0, o1);
        end

        // reset in the middle of a step on a populated board
        run_op(1'b1, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b0, lat);
        @(negedge clk); step_req = 1'b1;
        @(negedge clk); step_req = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy_wrap", busy0, 0);
        chk("midrst_busy_dead", busy1, 0);
        chk("midrst_done", done0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        scan(o0, o1);
        chk("midrst_ones_wrap", o0, 0);
        chk("midrst_ones_dead", o1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
